ball_collision: RTL and testbench

Per-update collision engine for the breakout datapath, sitting directly upstream of the brick drawing/health stage. On each ball-update strobe it tests the ball's next step against the screen walls, the paddle and the 8x4 brick grid. It reads brick health through an indexed lookup port and reports bounce directions, the struck brick index and the contact point. The brick stage and the ball mover consume these results.

---
 rtl/ball_collision.sv | 189 ++++++++++++++++++
 tb/tb_ball_collision.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ball_collision.sv
// Per-update ball collision engine: wall/paddle tests, then X, Y and corner
// brick probes through an indexed health lookup, one result strobe per update.
module ball_collision #(
    parameter int unsigned ANCHOR_LEFT = 2,
    parameter int unsigned ANCHOR_TOP  = 4,
    parameter int unsigned PITCH_X     = 20,
    parameter int unsigned PITCH_Y     = 12,
    parameter int unsigned BRICK_W     = 16,
    parameter int unsigned BRICK_H     = 8,
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter int unsigned PADDLE_Y    = 110,
    parameter int unsigned PADDLE_W    = 24
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] BALL_X,
    input  logic [7:0] BALL_Y,
    input  logic       DIR_X,
    input  logic       DIR_Y,
    input  logic [7:0] PADDLE_X,
    output logic [4:0] HEALTH_IDX,
    input  logic [2:0] HEALTH_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic       BOUNCE_LEFT,
    output logic       BOUNCE_RIGHT,
    output logic       BOUNCE_UP,
    output logic       BOUNCE_DOWN,
    output logic       HIT,
    output logic       MISS,
    output logic [4:0] HIT_IDX,
    output logic [7:0] COLLISION_X,
    output logic [7:0] COLLISION_Y
);

    typedef enum logic [3:0] {
        IDLE, WALL, PX_ADDR, PX_CHK, PY_ADDR, PY_CHK, PC_ADDR, PC_CHK, FIN
    } state_e;

    state_e     state_q;
    logic [7:0] x_q, y_q, pad_q;
    logic       dir_x_q, dir_y_q;
    logic       wall_bl_q, wall_br_q, wall_bu_q, wall_bd_q, wall_miss_q;
    logic [4:0] health_idx_q, hit_idx_q;
    logic [7:0] coll_x_q, coll_y_q;
    logic       busy_q, done_q, bl_q, br_q, bu_q, bd_q, hit_q, miss_q;

    logic [7:0] nx, ny, px, py, dx, dy;
    logic       use_nx, use_ny, in_grid, is_chk, brick_hit, to_fin;
    logic [4:0] idx;

    // Probe point for the current state and its grid membership / brick index
    always_comb begin
        nx      = dir_x_q ? x_q + 8'd1 : x_q - 8'd1;
        ny      = dir_y_q ? y_q + 8'd1 : y_q - 8'd1;
        use_nx  = (state_q == PX_ADDR) || (state_q == PX_CHK) ||
                  (state_q == PC_ADDR) || (state_q == PC_CHK);
        use_ny  = (state_q == PY_ADDR) || (state_q == PY_CHK) ||
                  (state_q == PC_ADDR) || (state_q == PC_CHK);
        px      = use_nx ? nx : x_q;
        py      = use_ny ? ny : y_q;
        dx      = px - 8'(ANCHOR_LEFT);
        dy      = py - 8'(ANCHOR_TOP);
        in_grid = (px >= 8'(ANCHOR_LEFT)) && (dx < 8'(8 * PITCH_X)) &&
                  ((dx % 8'(PITCH_X)) < 8'(BRICK_W)) &&
                  (py >= 8'(ANCHOR_TOP)) && (dy < 8'(4 * PITCH_Y)) &&
                  ((dy % 8'(PITCH_Y)) < 8'(BRICK_H));
        idx     = {2'(dy / 8'(PITCH_Y)), 3'(dx / 8'(PITCH_X))};
        is_chk  = (state_q == PX_CHK) || (state_q == PY_CHK) || (state_q == PC_CHK);
        brick_hit = is_chk && (HEALTH_IN != 3'd0);
        to_fin  = ((state_q == PC_ADDR) && !in_grid) || brick_hit || (state_q == PC_CHK);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q      <= IDLE;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            pad_q        <= 8'd0;
            dir_x_q      <= 1'b0;
            dir_y_q      <= 1'b0;
            wall_bl_q    <= 1'b0;
            wall_br_q    <= 1'b0;
            wall_bu_q    <= 1'b0;
            wall_bd_q    <= 1'b0;
            wall_miss_q  <= 1'b0;
            health_idx_q <= 5'd0;
            hit_idx_q    <= 5'd0;
            coll_x_q     <= 8'd0;
            coll_y_q     <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bl_q         <= 1'b0;
            br_q         <= 1'b0;
            bu_q         <= 1'b0;
            bd_q         <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (START) begin
                    x_q     <= BALL_X;
                    y_q     <= BALL_Y;
                    pad_q   <= PADDLE_X;
                    dir_x_q <= DIR_X;
                    dir_y_q <= DIR_Y;
                    busy_q  <= 1'b1;
                    state_q <= WALL;
                end
                WALL: begin
                    wall_br_q <= (x_q == 8'd0) && !dir_x_q;
                    wall_bl_q <= (x_q == 8'(SCREEN_W - 1)) && dir_x_q;
                    wall_bd_q <= (y_q == 8'd0) && !dir_y_q;
                    if (dir_y_q && (({1'b0, y_q} + 9'd1) == 9'(PADDLE_Y)) && (x_q >= pad_q) &&
                        ({1'b0, x_q} <= ({1'b0, pad_q} + 9'(PADDLE_W - 1)))) begin
                        wall_bu_q   <= 1'b1;
                        wall_miss_q <= 1'b0;
                    end else begin
                        wall_bu_q   <= 1'b0;
                        wall_miss_q <= dir_y_q && (y_q == 8'(SCREEN_H - 1));
                    end
                    state_q <= PX_ADDR;
                end
                PX_ADDR: begin
                    if (in_grid) health_idx_q <= idx;
                    state_q <= in_grid ? PX_CHK : PY_ADDR;
                end
                PX_CHK:  state_q <= brick_hit ? FIN : PY_ADDR;
                PY_ADDR: begin
                    if (in_grid) health_idx_q <= idx;
                    state_q <= in_grid ? PY_CHK : PC_ADDR;
                end
                PY_CHK:  state_q <= brick_hit ? FIN : PC_ADDR;
                PC_ADDR: begin
                    if (in_grid) health_idx_q <= idx;
                    state_q <= in_grid ? PC_CHK : FIN;
                end
                PC_CHK:  state_q <= FIN;
                FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    bl_q    <= 1'b0;
                    br_q    <= 1'b0;
                    bu_q    <= 1'b0;
                    bd_q    <= 1'b0;
                    hit_q   <= 1'b0;
                    miss_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Result strobe is loaded on the edge entering FIN
            if (to_fin) begin
                done_q <= 1'b1;
                bl_q   <= wall_bl_q | (brick_hit & use_nx &  dir_x_q);
                br_q   <= wall_br_q | (brick_hit & use_nx & ~dir_x_q);
                bu_q   <= wall_bu_q | (brick_hit & use_ny &  dir_y_q);
                bd_q   <= wall_bd_q | (brick_hit & use_ny & ~dir_y_q);
                hit_q  <= brick_hit;
                miss_q <= wall_miss_q;
                if (brick_hit) begin
                    hit_idx_q <= health_idx_q;
                    coll_x_q  <= px;
                    coll_y_q  <= py;
                end else begin
                    coll_x_q  <= x_q;
                    coll_y_q  <= y_q;
                end
            end
        end
    end

    assign HEALTH_IDX   = health_idx_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign BOUNCE_LEFT  = bl_q;
    assign BOUNCE_RIGHT = br_q;
    assign BOUNCE_UP    = bu_q;
    assign BOUNCE_DOWN  = bd_q;
    assign HIT          = hit_q;
    assign MISS         = miss_q;
    assign HIT_IDX      = hit_idx_q;
    assign COLLISION_X  = coll_x_q;
    assign COLLISION_Y  = coll_y_q;

endmodule

// File: tb/tb_ball_collision.sv
// Directed bench for ball_collision: latency, bounce/hit/miss flags, indices,
// contact point, reset abort and START-while-busy.
module tb_ball_collision;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] ball_x, ball_y, paddle_x;
    logic       dir_x, dir_y;
    logic [2:0] health_in;
    logic [4:0] health_idx, hit_idx;
    logic       busy, done, b_left, b_right, b_up, b_down, hit, miss;
    logic [7:0] coll_x, coll_y;

    int n_checks = 0;
    int n_errors = 0;

    ball_collision dut (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .START        (start),
        .BALL_X       (ball_x),
        .BALL_Y       (ball_y),
        .DIR_X        (dir_x),
        .DIR_Y        (dir_y),
        .PADDLE_X     (paddle_x),
        .HEALTH_IDX   (health_idx),
        .HEALTH_IN    (health_in),
        .BUSY         (busy),
        .DONE         (done),
        .BOUNCE_LEFT  (b_left),
        .BOUNCE_RIGHT (b_right),
        .BOUNCE_UP    (b_up),
        .BOUNCE_DOWN  (b_down),
        .HIT          (hit),
        .MISS         (miss),
        .HIT_IDX      (hit_idx),
        .COLLISION_X  (coll_x),
        .COLLISION_Y  (coll_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] bx, input logic [7:0] by, input logic dxi,
                         input logic dyi, input logic [7:0] pad, input logic [2:0] hp);
        ball_x    = bx;
        ball_y    = by;
        dir_x     = dxi;
        dir_y     = dyi;
        paddle_x  = pad;
        health_in = hp;
    endtask

    // flags packed as {left, right, up, down, hit, miss}
    task automatic run_case(input string tag, input logic [7:0] bx, input logic [7:0] by,
                            input logic dxi, input logic dyi, input logic [7:0] pad,
                            input logic [2:0] hp, input int exp_cyc, input logic [5:0] exp_flags,
                            input logic [4:0] exp_hidx, input logic [4:0] exp_hlidx,
                            input logic [7:0] ecx, input logic [7:0] ecy);
        int cyc;
        drive(bx, by, dxi, dyi, pad, hp);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, ".latency"}, cyc, exp_cyc);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".flags"}, {b_left, b_right, b_up, b_down, hit, miss}, exp_flags);
        check({tag, ".hit_idx"}, hit_idx, exp_hidx);
        check({tag, ".health_idx"}, health_idx, exp_hlidx);
        check({tag, ".coll_x"}, coll_x, ecx);
        check({tag, ".coll_y"}, coll_y, ecy);
        tick();
        check({tag, ".done_low"}, done, 0);
        check({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        int n_done;
        rst   = 1'b1;
        start = 1'b0;
        drive(8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 3'd0);
        tick();
        tick();
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.outs", {health_idx, hit_idx, coll_x, coll_y,
                             b_left, b_right, b_up, b_down, hit, miss}, 0);
        rst = 1'b0;
        tick();

        // Reset abort during PX_CHK: X probe (31,16) sits in brick 9
        drive(8'd30, 8'd16, 1'b1, 1'b1, 8'd100, 3'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort.health_idx_pre", health_idx, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.outs", {done, health_idx, hit_idx, coll_x, coll_y,
                             b_left, b_right, b_up, b_down, hit, miss}, 0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_done += int'(done);
        end
        check("abort.no_done", n_done, 0);

        run_case("left_wall", 8'd0,   8'd60,  1'b0, 1'b1, 8'd100, 3'd0, 5, 6'b010000, 5'd0, 5'd0, 8'd0,   8'd60);
        run_case("x_hit",     8'd18,  8'd6,   1'b0, 1'b1, 8'd100, 3'd4, 4, 6'b010010, 5'd0, 5'd0, 8'd17,  8'd6);
        run_case("y_hit",     8'd30,  8'd15,  1'b1, 1'b1, 8'd100, 3'd3, 5, 6'b001010, 5'd9, 5'd9, 8'd30,  8'd16);
        run_case("dead",      8'd30,  8'd15,  1'b1, 1'b1, 8'd100, 3'd0, 7, 6'b000000, 5'd9, 5'd9, 8'd30,  8'd15);
        run_case("all_probe", 8'd10,  8'd6,   1'b1, 1'b1, 8'd100, 3'd0, 8, 6'b000000, 5'd9, 5'd0, 8'd10,  8'd6);
        run_case("corner",    8'd1,   8'd3,   1'b1, 1'b1, 8'd100, 3'd2, 6, 6'b101010, 5'd0, 5'd0, 8'd2,   8'd4);
        run_case("paddle",    8'd50,  8'd109, 1'b1, 1'b1, 8'd40,  3'd0, 5, 6'b001000, 5'd0, 5'd0, 8'd50,  8'd109);
        run_case("miss",      8'd50,  8'd119, 1'b1, 1'b1, 8'd60,  3'd0, 5, 6'b000001, 5'd0, 5'd0, 8'd50,  8'd119);
        run_case("rt_top",    8'd159, 8'd0,   1'b1, 1'b0, 8'd100, 3'd0, 5, 6'b100100, 5'd0, 5'd0, 8'd159, 8'd0);

        // START pulsed while busy must not spawn a second update
        drive(8'd18, 8'd6, 1'b0, 1'b1, 8'd100, 3'd4);
        start = 1'b1;
        tick();
        n_done = int'(done);
        for (int i = 0; i < 15; i++) begin
            start = (i == 1);
            tick();
            n_done += int'(done);
        end
        start = 1'b0;
        check("busy_start.done_count", n_done, 1);
        check("busy_start.idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
